strand_serializer: RTL and testbench

Parallel-to-serial reader for packed DNA words of N 2-bit bases. It accepts one word on a valid/ready input, then emits its bases one per handshake on a valid/ready output. It can optionally reverse base order and re-apply the base complement (00<->01, 10<->11), so a complemented word is read back as the original strand or as its reverse complement. It sits downstream of the word-level complement stage and feeds base-serial consumers such as matchers and counters.

---
 rtl/strand_serializer_if.sv | 23 ++
 rtl/strand_serializer.sv | 66 ++++++
 tb/tb_strand_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/strand_serializer_if.sv
// strand_serializer_if: word-in / base-out handshake bundle for the strand serializer
`timescale 1ns/1ps
interface strand_serializer_if #(parameter int N = 4);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic          word_valid;
  logic          word_ready;
  logic [2*N-1:0] word_in;
  logic          rev_in;
  logic          comp_in;
  logic          base_valid;
  logic          base_ready;
  logic [1:0]    base_out;
  logic          base_last;
  logic [IW-1:0] base_idx;
  modport master (
    output word_valid, word_in, rev_in, comp_in, base_ready,
    input  word_ready, base_valid, base_out, base_last, base_idx
  );
  modport slave (
    input  word_valid, word_in, rev_in, comp_in, base_ready,
    output word_ready, base_valid, base_out, base_last, base_idx
  );
endinterface

// File: rtl/strand_serializer.sv
// strand_serializer: packed DNA word to base-serial stream with optional reverse/complement
`timescale 1ns/1ps
module strand_serializer #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst_n,
  strand_serializer_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LASTI = IW'(N - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t         state_q;
  logic [2*N-1:0] sr_q, word_n;
  logic           rev_q, comp_q, rev_n, comp_n;
  logic [IW-1:0]  cnt_q, cnt_d, k_d, idx_q;
  logic [1:0]     base_q, base_d;
  logic           last_q, last_d;
  logic           ready, accept, hs;
  assign ready  = rst_n && (state_q == IDLE || (last_q && bus.base_ready));
  assign accept = bus.word_valid && ready;
  assign hs     = (state_q == SEND) && bus.base_ready;
  assign bus.word_ready = ready;
  assign bus.base_valid = (state_q == SEND);
  assign bus.base_out   = base_q;
  assign bus.base_last  = last_q;
  assign bus.base_idx   = idx_q;
  // Next beat: a freshly accepted word starts at beat 0, otherwise the count advances on a handshake
  always_comb begin
    word_n = accept ? bus.word_in : sr_q;
    rev_n  = accept ? bus.rev_in : rev_q;
    comp_n = accept ? bus.comp_in : comp_q;
    cnt_d  = accept ? '0 : hs ? cnt_q + IW'(1) : cnt_q;
    k_d    = rev_n ? LASTI - cnt_d : cnt_d;
    base_d = word_n[{k_d, 1'b0} +: 2] ^ {1'b0, comp_n};
    last_d = (cnt_d == LASTI);
  end
  // Control FSM with registered base outputs; outputs only move on accept or a non-final handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rev_q   <= 1'b0;
      comp_q  <= 1'b0;
      cnt_q   <= '0;
      base_q  <= 2'b00;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        state_q <= SEND;
        sr_q    <= bus.word_in;
        rev_q   <= bus.rev_in;
        comp_q  <= bus.comp_in;
      end else if (hs && last_q) begin
        state_q <= IDLE;
      end
      cnt_q <= cnt_d;
      if (accept || (hs && !last_q)) begin
        base_q <= base_d;
        idx_q  <= k_d;
        last_q <= last_d;
      end
    end
  end
endmodule

// File: tb/tb_strand_serializer.sv
// tb_strand_serializer: scoreboard bench for N=4 and N=1 serializer instances
`timescale 1ns/1ps
module tb_strand_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc4, acc1, t0;
  logic [4:0] q4[$];
  logic [4:0] q1[$];
  logic stall4 = 1'b0, stall1 = 1'b0;
  logic [4:0] prev4, prev1;
  logic [11:0] pat = 12'b1001_0110_1001;

  strand_serializer_if #(.N(4)) b4();
  strand_serializer_if #(.N(1)) b1();
  strand_serializer #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  strand_serializer #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic e4(logic [1:0] b, logic [1:0] i, logic l);
    q4.push_back({b, i, l});
  endtask

  task automatic e1(logic [1:0] b, logic l);
    q1.push_back({b, 2'b00, l});
  endtask

  task automatic send4(logic [7:0] w, logic r, logic c);
    b4.word_in = w; b4.rev_in = r; b4.comp_in = c; b4.word_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b4.word_ready) break;
    end
    chk("accept4", b4.word_ready, 1);
    @(posedge clk); #1;
    acc4 = cyc;
  endtask

  task automatic send1(logic [1:0] w, logic r, logic c);
    b1.word_in = w; b1.rev_in = r; b1.comp_in = c; b1.word_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.word_ready) break;
    end
    chk("accept1", b1.word_ready, 1);
    @(posedge clk); #1;
    acc1 = cyc;
  endtask

  task automatic wait4();
    for (int i = 0; i < 40 && (q4.size() != 0 || b4.base_valid); i++) @(negedge clk);
    chk("drain4", q4.size(), 0);
    chk("idle4", b4.base_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait1();
    for (int i = 0; i < 40 && (q1.size() != 0 || b1.base_valid); i++) @(negedge clk);
    chk("drain1", q1.size(), 0);
    chk("idle1", b1.base_valid, 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [4:0] cur;
    cur = {b4.base_out, b4.base_idx, b4.base_last};
    if (!rst_n) stall4 = 1'b0;
    else begin
      if (stall4) begin
        chk("hold4", cur, prev4);
        chk("valid_held4", b4.base_valid, 1);
      end
      if (b4.base_valid) begin
        if (q4.size() == 0) chk("unexpected4", b4.base_valid, 0);
        else begin
          chk("word_ready4", b4.word_ready, b4.base_ready && q4[0][0]);
          if (b4.base_ready) begin
            chk("beat4", cur, q4.pop_front());
            stall4 = 1'b0;
          end else begin
            stall4 = 1'b1;
            prev4 = cur;
          end
        end
      end else stall4 = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [4:0] cur;
    cur = {b1.base_out, 1'b0, b1.base_idx, b1.base_last};
    if (!rst_n) stall1 = 1'b0;
    else begin
      if (stall1) begin
        chk("hold1", cur, prev1);
        chk("valid_held1", b1.base_valid, 1);
      end
      if (b1.base_valid) begin
        if (q1.size() == 0) chk("unexpected1", b1.base_valid, 0);
        else begin
          chk("word_ready1", b1.word_ready, b1.base_ready && q1[0][0]);
          if (b1.base_ready) begin
            chk("beat1", cur, q1.pop_front());
            stall1 = 1'b0;
          end else begin
            stall1 = 1'b1;
            prev1 = cur;
          end
        end
      end else stall1 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b4.word_valid = 1'b0; b4.word_in = '0; b4.rev_in = 1'b0; b4.comp_in = 1'b0; b4.base_ready = 1'b1;
    b1.word_valid = 1'b0; b1.word_in = '0; b1.rev_in = 1'b0; b1.comp_in = 1'b0; b1.base_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid4", b4.base_valid, 0);
    chk("rst_outs4", {b4.base_out, b4.base_idx, b4.base_last}, 0);
    chk("rst_ready4", b4.word_ready, 0);
    chk("rst_valid1", b1.base_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready4", b4.word_ready, 1);
    chk("idle_ready1", b1.word_ready, 1);
    @(posedge clk); #1;

    // forward, no complement; inputs scrambled after acceptance
    e4(2'b00, 2'd0, 0); e4(2'b01, 2'd1, 0); e4(2'b10, 2'd2, 0); e4(2'b11, 2'd3, 1);
    send4(8'hE4, 0, 0);
    b4.word_valid = 1'b0; b4.word_in = 8'h5A; b4.rev_in = 1'b1; b4.comp_in = 1'b1;
    chk("latency4", b4.base_valid, 1);
    wait4();

    // reverse complement
    e4(2'b10, 2'd3, 0); e4(2'b11, 2'd2, 0); e4(2'b00, 2'd1, 0); e4(2'b01, 2'd0, 1);
    send4(8'hE4, 1, 1);
    b4.word_valid = 1'b0;
    wait4();

    // backpressure
    e4(2'b11, 2'd3, 0); e4(2'b10, 2'd2, 0); e4(2'b01, 2'd1, 0); e4(2'b00, 2'd0, 1);
    send4(8'hE4, 1, 0);
    b4.word_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b4.base_ready = pat[i];
      @(posedge clk); #1;
    end
    b4.base_ready = 1'b1;
    wait4();

    // back-to-back words with no bubble
    e4(2'b00, 2'd0, 0); e4(2'b01, 2'd1, 0); e4(2'b10, 2'd2, 0); e4(2'b11, 2'd3, 1);
    e4(2'b11, 2'd0, 0); e4(2'b10, 2'd1, 0); e4(2'b01, 2'd2, 0); e4(2'b00, 2'd3, 1);
    send4(8'hE4, 0, 0);
    t0 = acc4;
    send4(8'h1B, 0, 0);
    chk("no_bubble", acc4 - t0, 4);
    b4.word_valid = 1'b0;
    wait4();

    // reset mid-word after two beats
    e4(2'b00, 2'd0, 0); e4(2'b01, 2'd1, 0);
    send4(8'hE4, 0, 0);
    b4.word_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b4.word_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", b4.base_valid, 0);
    chk("midrst_outs", {b4.base_out, b4.base_idx, b4.base_last}, 0);
    chk("midrst_ready", b4.word_ready, 0);
    chk("midrst_beats", q4.size(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    e4(2'b01, 2'd0, 0); e4(2'b01, 2'd1, 0); e4(2'b01, 2'd2, 0); e4(2'b01, 2'd3, 1);
    send4(8'h00, 0, 1);
    b4.word_valid = 1'b0;
    wait4();

    // single-base words
    e1(2'b11, 1);
    send1(2'b10, 0, 1);
    b1.word_valid = 1'b0;
    chk("latency1", b1.base_valid, 1);
    wait1();
    e1(2'b01, 1);
    send1(2'b01, 1, 0);
    b1.word_valid = 1'b0;
    wait1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
